mc_ctrl: RTL
============

# mc_ctrl

Multicycle RISC-V RV32I control unit. It replaces the single-cycle opcode-only main decoder with a state machine that sequences each instruction over several cycles on one shared ALU and one shared memory port. It sits between the instruction register and the datapath muxes/enables, and adds a memory ready/request handshake, an optional memory timeout, illegal-opcode trapping, and a retired-instruction counter.

## Interface
Parameters:
- CSR_EN, 1, 1 = opcode 111_0011 (csrrw) supported; 0 = treated as illegal
- HALT_ON_ILLEGAL, 1, 1 = TRAP is terminal until reset; 0 = TRAP returns to FETCH after one cycle
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ready; 0 disables the timeout
- CNT_W, 32, width of the instret counter

Ports:
- clk, in, 1, clock; all state updates on the rising edge
- rst_n, in, 1, asynchronous active-low reset
- opcode, in, 7, instr[6:0] from the instruction register; sampled only in DECODE
- Btaken, in, 1, branch condition from the comparator
- mem_ready, in, 1, memory completes the current request this cycle
- mem_req, out, 1, memory request valid
- MemWrite, out, 1, the request is a write
- AdrSrc, out, 1, address select: 0 = PC, 1 = ALUOut
- IRWrite, out, 1, load the instruction register and oldPC
- PCWrite, out, 1, PC enable (already includes Branch & Btaken)
- RegWrite, out, 1, register file write
- ResultSrc, out, 2, result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = CSR rdata
- ALUSrc_A, out, 2, ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- ALUSrc_B, out, 2, ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- ImmSrc, out, 3, immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUop, out, 2, ALU operation: 00 = add, 01 = sub/compare, 10 = funct decode
- Branch, out, 1, branch state active
- Csr, out, 1, CSR access
- illegal, out, 1, one-cycle pulse on entry to TRAP because of the opcode
- bus_err, out, 1, one-cycle pulse on entry to TRAP because of a timeout
- instret, out, CNT_W, retired-instruction count

## Operation
- The FSM state is 5 bits. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, CSR, TRAP.
- All outputs are Moore decodes of the state, with three exceptions:
  - PCWrite and IRWrite in FETCH are qualified by mem_ready.
  - PCWrite in BRANCH equals Btaken.
  - illegal and bus_err are registered pulses.
- Every control output not listed for a state is 0.

Per-state behaviour:
- FETCH: mem_req=1, AdrSrc=0, ALUSrc_A=00, ALUSrc_B=10, ALUop=00, ResultSrc=10.
  - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrc_A=01, ALUSrc_B=01, ALUop=00; ImmSrc=011 if opcode=jal, else 010. This precomputes the branch/jal target into ALUOut. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXECR
  - I-ALU → EXECI
  - branch → BRANCH
  - jal → JAL
  - jalr → JALR1
  - lui → LUI
  - auipc → AUIPC
  - csrrw → CSR (only if CSR_EN)
  - anything else → TRAP with illegal pulse
- MEMADR: A=10, B=01, ALUop=00; ImmSrc=001 for sw, 000 for lw. Next: MEMWR for sw, MEMRD for lw.
- MEMRD: mem_req=1, AdrSrc=1. On ready → MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01 → FETCH.
- MEMWR: mem_req=1, MemWrite=1, AdrSrc=1. On ready → FETCH.
- EXECR: A=10, B=00, ALUop=10 → ALUWB.
- EXECI: A=10, B=01, ImmSrc=000, ALUop=10 → ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00 → FETCH.
- BRANCH: Branch=1, A=10, B=00, ALUop=01, ResultSrc=00, PCWrite=Btaken → FETCH.
- JAL: PCWrite=1, ResultSrc=00, A=01, B=10, ALUop=00 (computes the link address) → ALUWB.
- JALR1: A=10, B=01, ImmSrc=000, ALUop=00 (target into ALUOut) → JALR2.
- JALR2: PCWrite=1, ResultSrc=00, A=01, B=10, ALUop=00 → ALUWB.
- LUI: A=11, B=01, ImmSrc=100 → ALUWB.
- AUIPC: A=01, B=01, ImmSrc=100 → ALUWB.
- CSR: Csr=1, RegWrite=1, ResultSrc=11 → FETCH.
- TRAP: all control outputs 0.
  - HALT_ON_ILLEGAL=1: stay in TRAP until reset.
  - HALT_ON_ILLEGAL=0: go to FETCH next cycle.

Retire counter:
- instret increments by 1 on every transition into FETCH from any state other than TRAP.
- It wraps modulo 2^CNT_W.

Timeout (MEM_TIMEOUT > 0):
- A wait counter clears on entry to FETCH, MEMRD and MEMWR, and increments on each cycle in those states with mem_ready=0.
- When it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with a bus_err pulse.
- mem_ready=1 on that same cycle wins: normal completion, no error.

## Timing
- Reset (rst_n=0, asynchronous):
  - State = FETCH, instret=0, wait counter=0, illegal=0, bus_err=0.
  - Outputs reflect FETCH, so mem_req=1 while in reset; PCWrite and IRWrite are gated to 0 while rst_n=0.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after the reset edge.
- Cycle counts with zero-wait memory (mem_ready=1 whenever requested):
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-ALU, lui, auipc: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
  - csrrw: 3 cycles
- Each memory wait cycle adds 1 cycle.
- mem_req is held asserted until mem_ready; MemWrite and AdrSrc are stable throughout the request.
- illegal and bus_err are high for exactly the first cycle in TRAP.

## Test plan
- Reset: assert rst_n=0 mid-MEMRD → state FETCH, instret=0, PCWrite=0 during reset; after release, the first fetch with mem_ready=1 gives IRWrite=1 and PCWrite=1.
- Sequence lw, sw, add, beq(Btaken=1), jal, jalr, lui, auipc, zero-wait → per-instruction cycle counts 5/4/4/3/4/5/4/4; instret=8; PCWrite high in BRANCH exactly when Btaken=1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEMRD → 11 total cycles; mem_req, AdrSrc=1 stable while waiting in MEMRD.
- Opcode 0000000, HALT_ON_ILLEGAL=1 → illegal pulses for 1 cycle, state stays TRAP for 20 cycles, instret unchanged; with HALT_ON_ILLEGAL=0 → FETCH after 1 cycle.
- MEM_TIMEOUT=4, mem_ready held 0 in MEMWR → bus_err pulse after 4 wait cycles; repeat with mem_ready=1 on the 4th wait cycle → no error, state FETCH.
- CSR_EN=0, opcode 1110011 → TRAP with illegal=1; CSR_EN=1 → Csr=1, RegWrite=1, ResultSrc=11 for one cycle; instret wraps from 2^CNT_W-1 to 0 (CNT_W=4 run of 16 instructions).

Source files
------------

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multicycle RV32I control unit.
//
// Sequences each instruction over several cycles so one ALU and one memory
// port can be shared. The FSM state drives the datapath mux selects and write
// enables (Moore decode), with a mem_req/mem_ready handshake on the memory
// port, an optional memory-wait timeout, illegal-opcode trapping and a
// retired-instruction counter.
//
// Parameters
//   CSR_EN          1 = csrrw (1110011) supported, 0 = csrrw traps as illegal
//   HALT_ON_ILLEGAL 1 = TRAP is terminal until reset, 0 = TRAP -> FETCH
//   MEM_TIMEOUT     max wait cycles for mem_ready (0 = no timeout)
//   CNT_W           width of instret (at least 2)
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opcode          instr[6:0], only looked at in DECODE
//   Btaken          branch comparator result
//   mem_ready       memory completes the current request this cycle
//   mem_req         memory request valid
//   MemWrite        request is a write
//   AdrSrc          address select: 0 = PC, 1 = ALUOut
//   IRWrite         load IR and oldPC
//   PCWrite         PC enable (branch condition already folded in)
//   RegWrite        register file write enable
//   ResultSrc       00 ALUOut, 01 Data, 10 ALUResult, 11 CSR rdata
//   ALUSrc_A        00 PC, 01 oldPC, 10 rs1, 11 zero
//   ALUSrc_B        00 rs2, 01 imm, 10 const 4
//   ImmSrc          000 I, 001 S, 010 B, 011 J, 100 U
//   ALUop           00 add, 01 sub/compare, 10 funct decode
//   Branch          branch state active
//   Csr             CSR access
//   illegal         one-cycle pulse on entering TRAP for a bad opcode
//   bus_err         one-cycle pulse on entering TRAP for a memory timeout
//   instret         retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CSR_EN          = 1,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int MEM_TIMEOUT     = 0,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             Btaken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrc_A,
    output logic [1:0]       ALUSrc_B,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       ALUop,
    output logic             Branch,
    output logic             Csr,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    // Counter just wide enough to hold MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT > 32'sd1) ? $clog2(MEM_TIMEOUT + 32'sd1) : 1;
    localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 32'sd0);

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_MEMADR = 5'd2,
        S_MEMRD  = 5'd3,
        S_MEMWB  = 5'd4,
        S_MEMWR  = 5'd5,
        S_EXECR  = 5'd6,
        S_EXECI  = 5'd7,
        S_ALUWB  = 5'd8,
        S_BRANCH = 5'd9,
        S_JAL    = 5'd10,
        S_JALR1  = 5'd11,
        S_JALR2  = 5'd12,
        S_LUI    = 5'd13,
        S_AUIPC  = 5'd14,
        S_CSR    = 5'd15,
        S_TRAP   = 5'd16
    } state_e;

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_inc_s;
    logic               wait_state_s;
    logic               timeout_s;
    logic               retire_s;
    logic               ir_write_s;
    logic               pc_write_s;
    logic               illegal_r;
    logic               bus_err_r;
    logic [CNT_W-1:0]   instret_r;

    // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a mem_ready in that same cycle takes precedence.
    assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign wait_inc_s   = wait_cnt_r + WAIT_W'(1'b1);
    assign timeout_s    = TIMEOUT_ON && wait_state_s && !mem_ready &&
                          (32'(wait_inc_s) >= 32'(MEM_TIMEOUT));

    // Retirement is any entry into FETCH except recovery from TRAP.
    assign retire_s = (state_nxt_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_TRAP);

    // The FETCH enables are forced low while reset is held so nothing is
    // written into PC/IR during an abort.
    assign IRWrite = ir_write_s & rst_n;
    assign PCWrite = pc_write_s & rst_n;
    assign illegal = illegal_r;
    assign bus_err = bus_err_r;
    assign instret = instret_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory wait counter: restarts on every state change, counts stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_nxt_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (wait_state_s && !mem_ready) begin
            wait_cnt_r <= wait_inc_s;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Trap cause pulses, high only in the first TRAP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            illegal_r <= (state_r == S_DECODE) && (state_nxt_s == S_TRAP);
            bus_err_r <= timeout_s && (state_nxt_s == S_TRAP);
        end
    end

    // Retired-instruction counter (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_W'(1'b1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next-state logic and Moore control decode
    always_comb begin
        state_nxt_s = state_r;
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        AdrSrc      = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrc_A    = 2'b00;
        ALUSrc_B    = 2'b00;
        ImmSrc      = 3'b000;
        ALUop       = 2'b00;
        Branch      = 1'b0;
        Csr         = 1'b0;

        case (state_r)
            S_FETCH: begin
                // PC + 4 on the ALU while the instruction is read at PC.
                mem_req   = 1'b1;
                ALUSrc_B  = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    state_nxt_s = S_DECODE;
                end else if (timeout_s) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end

            S_DECODE: begin
                // oldPC + imm precomputes the branch/jal target into ALUOut.
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b01;
                if (opcode == OP_JAL) begin
                    ImmSrc = 3'b011;
                end else begin
                    ImmSrc = 3'b010;
                end
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt_s = S_MEMADR;
                    OP_RTYPE:          state_nxt_s = S_EXECR;
                    OP_IALU:           state_nxt_s = S_EXECI;
                    OP_BRANCH:         state_nxt_s = S_BRANCH;
                    OP_JAL:            state_nxt_s = S_JAL;
                    OP_JALR:           state_nxt_s = S_JALR1;
                    OP_LUI:            state_nxt_s = S_LUI;
                    OP_AUIPC:          state_nxt_s = S_AUIPC;
                    OP_CSR: begin
                        if (CSR_EN != 0) begin
                            state_nxt_s = S_CSR;
                        end else begin
                            state_nxt_s = S_TRAP;
                        end
                    end
                    default:           state_nxt_s = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                // opcode is still held in the IR, so it picks load vs store here.
                ALUSrc_A = 2'b10;
                ALUSrc_B = 2'b01;
                if (opcode == OP_STORE) begin
                    ImmSrc      = 3'b001;
                    state_nxt_s = S_MEMWR;
                end else begin
                    ImmSrc      = 3'b000;
                    state_nxt_s = S_MEMRD;
                end
            end

            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_MEMWB;
                end else if (timeout_s) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end

            S_MEMWB: begin
                RegWrite    = 1'b1;
                ResultSrc   = 2'b01;
                state_nxt_s = S_FETCH;
            end

            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                end else if (timeout_s) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end

            S_EXECR: begin
                ALUSrc_A    = 2'b10;
                ALUSrc_B    = 2'b00;
                ALUop       = 2'b10;
                state_nxt_s = S_ALUWB;
            end

            S_EXECI: begin
                ALUSrc_A    = 2'b10;
                ALUSrc_B    = 2'b01;
                ImmSrc      = 3'b000;
                ALUop       = 2'b10;
                state_nxt_s = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite    = 1'b1;
                ResultSrc   = 2'b00;
                state_nxt_s = S_FETCH;
            end

            S_BRANCH: begin
                // Target already sits in ALUOut from DECODE.
                Branch      = 1'b1;
                ALUSrc_A    = 2'b10;
                ALUSrc_B    = 2'b00;
                ALUop       = 2'b01;
                ResultSrc   = 2'b00;
                pc_write_s  = Btaken;
                state_nxt_s = S_FETCH;
            end

            S_JAL: begin
                // PC <- ALUOut (target) while the ALU forms oldPC + 4 for rd.
                pc_write_s  = 1'b1;
                ResultSrc   = 2'b00;
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b10;
                state_nxt_s = S_ALUWB;
            end

            S_JALR1: begin
                ALUSrc_A    = 2'b10;
                ALUSrc_B    = 2'b01;
                ImmSrc      = 3'b000;
                state_nxt_s = S_JALR2;
            end

            S_JALR2: begin
                pc_write_s  = 1'b1;
                ResultSrc   = 2'b00;
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b10;
                state_nxt_s = S_ALUWB;
            end

            S_LUI: begin
                ALUSrc_A    = 2'b11;
                ALUSrc_B    = 2'b01;
                ImmSrc      = 3'b100;
                state_nxt_s = S_ALUWB;
            end

            S_AUIPC: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b01;
                ImmSrc      = 3'b100;
                state_nxt_s = S_ALUWB;
            end

            S_CSR: begin
                Csr         = 1'b1;
                RegWrite    = 1'b1;
                ResultSrc   = 2'b11;
                state_nxt_s = S_FETCH;
            end

            S_TRAP: begin
                if (HALT_ON_ILLEGAL != 0) begin
                    state_nxt_s = S_TRAP;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end

            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

endmodule
